sccb_responder: RTL and testbench
=================================

Name: sccb_responder

Overview:
- SCCB slave (responder) that answers the team's SCCB master: 3-phase write, 2-phase write and 2-phase read.
- Holds an internal 256x8 register file. Used as a sensor stand-in in simulation and as an on-FPGA loopback target for the SCCB master.
- Oversamples the bus with the system clock.
- Drives SDA only as an open-drain pull-down enable. The top level resolves the pin.

Parameters:
DEV_ID, 7'h21, 7-bit device ID; matching write byte is 0x42, read byte is 0x43.
SYNC_STAGES, 2, synchronizer flops on the SCL and SDA inputs (minimum 2).

Ports:
clk  input  1  system clock; must be at least 8x the SCL frequency.
reset  input  1  synchronous, active-high.
sccb_clk_in  input  1  SCL from the pin.
sccb_data_in  input  1  SDA from the pin.
sccb_data_oe  output  1  1 = pull SDA low; 0 = release.
wr_strobe  output  1  one-clk pulse when a register is written.
wr_addr  output  8  address of that write, valid with wr_strobe.
wr_data  output  8  data of that write, valid with wr_strobe.
busy  output  1  1 when state is not IDLE.
cfg_addr  input  8  backdoor read address.
cfg_data  output  8  regfile[cfg_addr], registered, 1-clk latency.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 and state goes to IDLE.
  - Bit counter and sub-address pointer clear to 0.
  - All 256 registers clear to 0x00. Clearing may take up to 256 clks via a sweep counter; busy stays high during the sweep and bus activity is ignored.
  - Reset mid-transaction behaves the same: SDA is released on the next clk.
- Input sampling:
  - SCL and SDA each pass through SYNC_STAGES flops, then one more register for edge detection.
  - An edge is detected SYNC_STAGES+1 clks after the pin changes.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on SCL rising, MSB first.
  - Responder SDA changes take effect 1 clk after a detected SCL fall.
- States: IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD, RD_NA, IGNORE.
- START from any state except the reset sweep: go to ID, clear the bit counter, release SDA.
- STOP from any state: go to IDLE, release SDA. A partial byte is discarded with no write.
- ID:
  - Shift in 8 bits.
  - Upper 7 bits equal DEV_ID: go to ID_ACK.
  - Otherwise go to IGNORE. IGNORE never drives SDA and waits for STOP or START.
- ACK phases (ID_ACK, SUB_ACK, DATA_ACK):
  - On the SCL fall after bit 8, oe=1.
  - On the SCL fall after the 9th bit, oe=0, except for a read (see RD below).
- Transitions after the ACK phases:
  - ID_ACK with R/W=0 goes to SUB.
  - ID_ACK with R/W=1 goes to RD.
  - SUB_ACK: latch the pointer, then go to DATA.
- DATA, on the 8th rising edge:
  - regfile[ptr] <= byte.
  - wr_strobe pulses for 1 clk with wr_addr=ptr and wr_data=byte.
  - Go to DATA_ACK, then IGNORE.
  - No auto-increment; further bytes in the same transaction are ignored.
- Two-phase write: STOP after SUB_ACK leaves only the pointer updated.
- RD:
  - The ID_ACK-release fall also presents bit7 of regfile[ptr]: oe = ~bit.
  - Each following SCL fall presents the next bit.
  - The fall after bit0 releases SDA, then go to RD_NA.
  - RD_NA samples the master's NA (don't-care), then goes to IGNORE.
- Simultaneous events:
  - START/STOP detection takes priority over a same-clk SCL edge.
  - A cfg_addr read and a wr_strobe write to the same address in the same clk return the old data.

Test Plan:
- Write 0x42, 0x12, 0x80, STOP:
  - oe=1 during all three 9th bits.
  - One wr_strobe with wr_addr=0x12 and wr_data=0x80.
  - cfg_addr=0x12 gives cfg_data=0x80 1 clk later.
- Write 0x42, 0x0A, 0x76, STOP; then 0x42, 0x0A, STOP; then read 0x43:
  - SDA bits seen by the master = 0x76.
  - oe=0 during the NA bit.
  - busy falls after STOP.
- Write 0x60, 0x12, 0x55:
  - oe stays 0 for the whole transaction, no wr_strobe.
  - busy=1 until STOP, then 0.
  - regfile[0x12] is unchanged.
- START, 0x42, ACK, 4 bits of sub-address, then repeated START, 0x42, 0x20, 0x11, STOP:
  - Exactly one write, addr 0x20 data 0x11.
- STOP after 4 bits of the DATA byte:
  - No wr_strobe; regfile is unchanged.
- Assert reset while RD has oe=1:
  - oe=0 on the next clk, busy held through the sweep.
  - All cfg reads return 0x00 afterwards.

Source files
------------

// File: rtl/sccb_responder_if.sv
// SCCB responder bus bundle: pin-side SCL/SDA, write
// notification and backdoor register-file read port.
interface sccb_responder_if;
  logic       sccb_clk_in;
  logic       sccb_data_in;
  logic       sccb_data_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_data;

  modport slave (
    input  sccb_clk_in, sccb_data_in, cfg_addr,
    output sccb_data_oe, wr_strobe, wr_addr,
    output wr_data, busy, cfg_data
  );

  modport master (
    output sccb_clk_in, sccb_data_in, cfg_addr,
    input  sccb_data_oe, wr_strobe, wr_addr,
    input  wr_data, busy, cfg_data
  );
endinterface

// File: rtl/sccb_responder.sv
// SCCB responder: oversampled SCL/SDA, 256x8 register file,
// 3-phase write, 2-phase write and 2-phase read.
module sccb_responder #(
  parameter logic [6:0] DEV_ID      = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  sccb_responder_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK,
    DATA, DATA_ACK, RD, RD_NA, IGNORE
  } state_t;

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] scl_sync_q, sda_sync_q;
  logic          scl_prev_q, sda_prev_q;
  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall;
  logic          start_c, stop_c;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          rw_q, rw_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [7:0]    rd_sh_q, rd_sh_d;
  logic          oe_q, oe_d;
  logic          wr_stb_q, wr_stb_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          sweep_q, sweep_d;
  logic [7:0]    sweep_cnt_q;
  logic [7:0]    cfg_data_q;
  logic          we;
  logic [7:0]    shifted;
  logic [7:0]    rd_byte;
  logic [7:0]    mem_q [256];

  assign scl_s    = scl_sync_q[NS-1];
  assign sda_s    = sda_sync_q[NS-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q
                  & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q
                  & ~sda_prev_q & sda_s;
  assign shifted  = {sh_q[6:0], sda_s};
  assign rd_byte  = mem_q[ptr_q];
  assign sweep_d  = sweep_q & (sweep_cnt_q != 8'hFF);

  // synchronize the pins, then keep one delayed copy for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[NS-2:0], bus.sccb_clk_in};
      sda_sync_q <= {sda_sync_q[NS-2:0], bus.sccb_data_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // protocol next-state; bus conditions win over SCL edges
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    rd_sh_d   = rd_sh_q;
    oe_d      = oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we        = 1'b0;
    if (sweep_q) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else if (start_c) begin
      state_d = ID;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        ID: begin
          if (scl_rise) begin
            sh_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d    = sda_s;
              state_d = (shifted[7:1] == DEV_ID)
                      ? ID_ACK : IGNORE;
            end
          end
        end
        ID_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else if (rw_q) begin
              oe_d    = ~rd_byte[7];
              rd_sh_d = {rd_byte[6:0], 1'b0};
              cnt_d   = 4'd1;
              state_d = RD;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = SUB;
            end
          end
        end
        SUB: begin
          if (scl_rise) begin
            sh_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) state_d = SUB_ACK;
          end
        end
        SUB_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              ptr_d   = sh_q;
              cnt_d   = '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            sh_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              we        = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shifted;
              state_d   = DATA_ACK;
            end
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        RD: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = RD_NA;
            end else begin
              oe_d    = ~rd_sh_q[7];
              rd_sh_d = {rd_sh_q[6:0], 1'b0};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        RD_NA: begin
          if (scl_rise) state_d = IGNORE;
        end
        IDLE, IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE) | sweep_d;
  end

  // protocol state, outputs and the post-reset clear sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      rd_sh_q     <= '0;
      oe_q        <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      sweep_q     <= 1'b1;
      sweep_cnt_q <= '0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      rd_sh_q     <= rd_sh_d;
      oe_q        <= oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      sweep_q     <= sweep_d;
      sweep_cnt_q <= sweep_q ? sweep_cnt_q + 8'd1
                             : sweep_cnt_q;
      cfg_data_q  <= mem_q[bus.cfg_addr];
    end
  end

  // register file: sweep clear has priority over bus writes
  always_ff @(posedge clk) begin
    if (sweep_q) begin
      mem_q[sweep_cnt_q] <= '0;
    end else if (we && !reset) begin
      mem_q[ptr_q] <= shifted;
    end
  end

  assign bus.sccb_data_oe = oe_q;
  assign bus.wr_strobe    = wr_stb_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.busy         = busy_q;
  assign bus.cfg_data     = cfg_data_q;
endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: directed vector table, corner
// sequences and random transactions against a regfile model.
module tb_sccb_responder;
  localparam int Q = 4;

  logic clk;
  logic reset;
  logic m_scl;
  logic m_sda;
  logic sda_pin;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  logic [7:0] last_a;
  logic [7:0] last_d;
  logic oe_ever;

  sccb_responder_if bus();

  sccb_responder #(.DEV_ID(7'h21), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign sda_pin          = m_sda & ~bus.sccb_data_oe;
  assign bus.sccb_clk_in  = m_scl;
  assign bus.sccb_data_in = sda_pin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_strobe === 1'b1) begin
      strobes++;
      last_a = bus.wr_addr;
      last_d = bus.wr_data;
    end
    if (bus.sccb_data_oe === 1'b1) oe_ever = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic bus_start();
    if (!m_scl) begin
      m_sda = 1'b1; wclk(Q);
      m_scl = 1'b1; wclk(Q);
    end
    m_sda = 1'b0; wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wclk(Q);
    m_scl = 1'b1; wclk(Q);
    m_sda = 1'b1; wclk(2 * Q);
  endtask

  task automatic bus_bit(input logic b, output logic s,
                         output logic o);
    m_sda = b;    wclk(Q);
    m_scl = 1'b1; wclk(Q);
    s = sda_pin;
    o = bus.sccb_data_oe;
    wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s, o);
    bus_bit(1'b1, s, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d,
                           output logic na_oe);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s, o);
      d[i] = s;
    end
    bus_bit(1'b1, s, na_oe);
  endtask

  task automatic cfg_read(input logic [7:0] a,
                          output logic [7:0] d);
    @(negedge clk);
    bus.cfg_addr = a;
    @(posedge clk);
    #1 d = bus.cfg_data;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 600) begin
      wclk(1);
      n++;
    end
    chk(nm, int'(bus.busy), 0);
  endtask

  typedef struct {
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] dat;
    int         n;
    logic [2:0] acks;
    int         wr;
    logic [7:0] ca;
    logic [7:0] cv;
    logic       oe_any;
  } vec_t;

  vec_t vt [4];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr;

  initial begin
    logic a0, a1, a2, na, s, o;
    logic [7:0] d;
    int s0, bad, n;

    m_scl = 1'b1;
    m_sda = 1'b1;
    bus.cfg_addr = '0;
    oe_ever = 1'b0;
    last_a = '0;
    last_d = '0;

    vt[0] = '{8'h42, 8'h12, 8'h80, 3, 3'b111, 1,
              8'h12, 8'h80, 1'b1};
    vt[1] = '{8'h42, 8'h0A, 8'h76, 3, 3'b111, 1,
              8'h0A, 8'h76, 1'b1};
    vt[2] = '{8'h60, 8'h12, 8'h55, 3, 3'b000, 0,
              8'h12, 8'h80, 1'b0};
    vt[3] = '{8'h42, 8'h0A, 8'h00, 2, 3'b110, 0,
              8'h0A, 8'h76, 1'b1};

    reset = 1'b1;
    wclk(3);
    @(posedge clk);
    #1;
    chk("rst_oe", int'(bus.sccb_data_oe), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_strobe", int'(bus.wr_strobe), 0);
    chk("rst_cfg", int'(bus.cfg_data), 0);
    @(negedge clk);
    reset = 1'b0;
    wclk(5);
    chk("sweep_busy", int'(bus.busy), 1);
    wait_idle("sweep_done");

    for (int i = 0; i < 4; i++) begin
      oe_ever = 1'b0;
      s0 = strobes;
      a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
      bus_start();
      send_byte(vt[i].id, a0);
      if (vt[i].n > 1) send_byte(vt[i].sub, a1);
      if (vt[i].n > 2) send_byte(vt[i].dat, a2);
      chk($sformatf("v%0d_busy_open", i),
          int'(bus.busy), 1);
      bus_stop();
      chk($sformatf("v%0d_ack0", i), int'(a0),
          int'(vt[i].acks[2]));
      chk($sformatf("v%0d_ack1", i), int'(a1),
          int'(vt[i].acks[1]));
      if (vt[i].n > 2)
        chk($sformatf("v%0d_ack2", i), int'(a2),
            int'(vt[i].acks[0]));
      chk($sformatf("v%0d_oe_any", i), int'(oe_ever),
          int'(vt[i].oe_any));
      chk($sformatf("v%0d_nwr", i), strobes - s0,
          vt[i].wr);
      if (vt[i].wr != 0) begin
        chk($sformatf("v%0d_waddr", i), int'(last_a),
            int'(vt[i].ca));
        chk($sformatf("v%0d_wdata", i), int'(last_d),
            int'(vt[i].cv));
      end
      wait_idle($sformatf("v%0d_busy_end", i));
      cfg_read(vt[i].ca, d);
      chk($sformatf("v%0d_cfg", i), int'(d),
          int'(vt[i].cv));
    end

    bus_start();
    send_byte(8'h43, a0);
    recv_byte(d, na);
    bus_stop();
    chk("rd_ack", int'(a0), 1);
    chk("rd_data", int'(d), 8'h76);
    chk("rd_na_oe", int'(na), 0);
    wait_idle("rd_busy_end");

    s0 = strobes;
    bus_start();
    send_byte(8'h42, a0);
    for (int i = 0; i < 4; i++) bus_bit(1'b0, s, o);
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h20, a1);
    send_byte(8'h11, a2);
    bus_stop();
    chk("rs_nwr", strobes - s0, 1);
    chk("rs_addr", int'(last_a), 8'h20);
    chk("rs_data", int'(last_d), 8'h11);

    s0 = strobes;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h30, a1);
    for (int i = 0; i < 4; i++) bus_bit(i[0], s, o);
    bus_stop();
    chk("part_nwr", strobes - s0, 0);
    cfg_read(8'h30, d);
    chk("part_cfg", int'(d), 0);

    bus_start();
    send_byte(8'h43, a0);
    n = 0;
    while (bus.sccb_data_oe !== 1'b1 && n < 10) begin
      wclk(1);
      n++;
    end
    chk("rdrst_oe_before", int'(bus.sccb_data_oe), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rdrst_oe_after", int'(bus.sccb_data_oe), 0);
    wclk(3);
    reset = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wclk(5);
    chk("rdrst_busy_sweep", int'(bus.busy), 1);
    wait_idle("rdrst_idle");
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      cfg_read(8'(a), d);
      if (d !== 8'h00) bad++;
    end
    chk("rdrst_all_zero", bad, 0);

    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    ref_ptr = 8'h00;
    for (int k = 0; k < 24; k++) begin
      int kind;
      logic good;
      logic [7:0] id, sub, dat, exp_d;
      kind = $urandom_range(0, 2);
      good = ($urandom_range(0, 3) != 0);
      sub  = 8'($urandom_range(0, 15));
      dat  = 8'($urandom_range(0, 255));
      if (good) begin
        id = 8'h42;
      end else begin
        id = 8'($urandom_range(0, 255));
        while (id[7:1] == 7'h21)
          id = 8'($urandom_range(0, 255));
      end
      id[0] = (kind == 2);
      s0 = strobes;
      bus_start();
      send_byte(id, a0);
      chk($sformatf("r%0d_ack_id", k), int'(a0),
          int'(good));
      if (kind == 2) begin
        exp_d = good ? ref_mem[ref_ptr] : 8'hFF;
        recv_byte(d, na);
        bus_stop();
        chk($sformatf("r%0d_rd", k), int'(d),
            int'(exp_d));
        chk($sformatf("r%0d_na", k), int'(na), 0);
      end else begin
        send_byte(sub, a1);
        chk($sformatf("r%0d_ack_sub", k), int'(a1),
            int'(good));
        if (kind == 0) send_byte(dat, a2);
        bus_stop();
        if (good) begin
          ref_ptr = sub;
          if (kind == 0) ref_mem[sub] = dat;
        end
      end
      chk($sformatf("r%0d_nwr", k), strobes - s0,
          (good && kind == 0) ? 1 : 0);
      wait_idle($sformatf("r%0d_idle", k));
    end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      cfg_read(8'(a), d);
      if (d !== ref_mem[a]) bad++;
    end
    chk("rand_regfile", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
